// File: rtl/secded_pkg.sv
// Shared types and constants for the SECDED(16,11) encoder and its decoder sibling.
package secded_pkg;
  localparam int DATA_W       = 11;
  localparam int CODE_W       = 16;
  localparam int ADDR_W       = 8;
  localparam int NUM_MSG_DEF  = 15;
  localparam int IN_BASE_DEF  = 0;
  localparam int OUT_BASE_DEF = 30;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;
endpackage

// File: rtl/secded_enc.sv
// Combinational extended-Hamming encoder: 11 data bits -> 16-bit codeword.
module secded_enc
  import secded_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);
  // data[k-1] holds message bit d_k
  logic p8, p4, p2, p1, p0;

  always_comb begin
    p8   = ^data[10:4];
    p4   = (^data[10:7]) ^ (^data[3:1]);
    p2   = data[10] ^ data[9] ^ data[6] ^ data[5] ^ data[3] ^ data[2] ^ data[0];
    p1   = data[10] ^ data[8] ^ data[6] ^ data[4] ^ data[3] ^ data[1] ^ data[0];
    p0   = (^data) ^ p8 ^ p4 ^ p2 ^ p1;
    code = {data[10:4], p8, data[3:1], p4, data[0], p2, p1, p0};
  end
endmodule

// File: rtl/secded_enc_engine.sv
// Reads raw 11-bit messages from byte memory, encodes them, writes 16-bit codewords back.
//   state | meaning
//   IDLE  | waiting for init after reset
//   RD_LO | mem_addr on low input byte, latch d[8:1]
//   RD_HI | mem_addr on high input byte, latch d[11:9]
//   WR_LO | writing codeword low byte
//   WR_HI | writing codeword high byte, advance or finish
//   DONE  | run complete, done held high until next init
module secded_enc_engine
  import secded_pkg::*;
#(
  parameter int NUM_MSG  = NUM_MSG_DEF,
  parameter int IN_BASE  = IN_BASE_DEF,
  parameter int OUT_BASE = OUT_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we
);
  localparam logic [ADDR_W-1:0] IN_B   = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_B  = ADDR_W'(OUT_BASE);
  localparam logic [7:0]        LAST   = 8'(NUM_MSG - 1);

  state_t              state;
  logic [7:0]          cnt;
  logic [7:0]          lo_q;
  logic [2:0]          hi_q;
  logic [ADDR_W-1:0]   slot_off;
  logic [DATA_W-1:0]   enc_data;
  logic [CODE_W-1:0]   code;

  assign slot_off = {cnt[ADDR_W-2:0], 1'b0};

  // In RD_HI the high bits are still on the bus, so the low codeword byte
  // is registered straight from mem_rdata rather than from hi_q.
  assign enc_data = (state == RD_HI) ? {mem_rdata[2:0], lo_q} : {hi_q, lo_q};

  secded_enc u_enc (
    .data (enc_data),
    .code (code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE, DONE: begin
          if (init) begin
            state    <= RD_LO;
            cnt      <= '0;
            mem_addr <= IN_B;
          end
        end
        RD_LO: begin
          lo_q     <= mem_rdata;
          state    <= RD_HI;
          mem_addr <= IN_B + slot_off + 8'd1;
        end
        RD_HI: begin
          hi_q      <= mem_rdata[2:0];
          state     <= WR_LO;
          mem_addr  <= OUT_B + slot_off;
          mem_we    <= 1'b1;
          mem_wdata <= code[7:0];
        end
        WR_LO: begin
          state     <= WR_HI;
          mem_addr  <= OUT_B + slot_off + 8'd1;
          mem_wdata <= code[15:8];
        end
        WR_HI: begin
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          if (cnt == LAST) begin
            state    <= DONE;
            mem_addr <= '0;
          end else begin
            cnt      <= cnt + 8'd1;
            state    <= RD_LO;
            mem_addr <= IN_B + slot_off + 8'd2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_secded_enc_engine.sv
// Scoreboard bench for secded_enc_engine against a positional Hamming reference model.
module tb_secded_enc_engine;
  import secded_pkg::*;

  localparam int N  = 15;
  localparam int IB = 0;
  localparam int OB = 30;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset, init;
  logic       done, mem_we;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_addr, tb_data;
  logic [7:0] lo_b [N];
  logic [7:0] hi_b [N];
  wr_t        exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  secded_enc_engine #(.NUM_MSG(N), .IN_BASE(IB), .OUT_BASE(OB)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  // Codeword bit j sits at Hamming position j; parity bits at powers of two,
  // data bits fill the rest in ascending order; bit 0 is overall parity.
  function automatic logic [15:0] ref_code(input logic [10:0] d);
    logic [15:0] c;
    logic        p;
    int          k;
    c = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (pos[b]) p ^= c[pos];
      c[1 << b] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0d data=%02h want none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            errors++;
            $display("FAIL write got addr=%0d data=%02h want addr=%0d data=%02h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
      end else begin
        checks++;
        if (mem_wdata !== 8'h00) begin
          errors++;
          $display("FAIL wdata_idle got=%02h want=00", mem_wdata);
        end
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load_msgs();
    for (int i = 0; i < N; i++) begin
      poke(8'(IB + 2*i), lo_b[i]);
      poke(8'(IB + 2*i + 1), hi_b[i]);
    end
  endtask

  task automatic push_exp(input int n);
    logic [15:0] c;
    for (int i = 0; i < n; i++) begin
      c = ref_code({hi_b[i][2:0], lo_b[i]});
      exp_q.push_back('{addr: 8'(OB + 2*i),     data: c[7:0]});
      exp_q.push_back('{addr: 8'(OB + 2*i + 1), data: c[15:8]});
    end
  endtask

  task automatic randomize_msgs();
    for (int i = 0; i < N; i++) begin
      lo_b[i] = 8'($urandom);
      hi_b[i] = 8'($urandom);
    end
  endtask

  task automatic run(input bit toggle, input string name);
    int   edges;
    logic first_done;
    @(negedge clk);
    init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
    edges = 0;
    first_done = 1'bx;
    do begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) first_done = done;
      init = (toggle && edges < 58) ? 1'($urandom) : 1'b0;
    end while (!done && edges < 200);
    check({name, "_done_fall"}, 32'(first_done), 32'd0);
    check({name, "_done_edge"}, 32'(edges), 32'd61);
    repeat (2) @(negedge clk);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // all-zero messages
    for (int i = 0; i < N; i++) begin lo_b[i] = 8'h00; hi_b[i] = 8'h00; end
    load_msgs();
    push_exp(N);
    run(1'b0, "zero");

    // directed corner messages, remainder random
    randomize_msgs();
    lo_b[0] = 8'hFF; hi_b[0] = 8'h07;
    lo_b[1] = 8'h01; hi_b[1] = 8'h00;
    lo_b[2] = 8'h00; hi_b[2] = 8'h04;
    lo_b[3] = 8'h01; hi_b[3] = 8'hF8;
    load_msgs();
    push_exp(N);
    run(1'b0, "directed");
    check("word_7ff", {16'd0, mem[OB+1], mem[OB]},   32'h0000FFFF);
    check("word_001", {16'd0, mem[OB+3], mem[OB+2]}, 32'h0000000F);
    check("word_400", {16'd0, mem[OB+5], mem[OB+4]}, 32'h00008117);
    check("word_f8",  {16'd0, mem[OB+7], mem[OB+6]}, 32'h0000000F);

    // random run, then a restart from DONE with fresh data
    randomize_msgs();
    load_msgs();
    push_exp(N);
    run(1'b0, "rand1");
    randomize_msgs();
    load_msgs();
    push_exp(N);
    run(1'b0, "rand2");

    // reset pulsed while message 7 is being read
    randomize_msgs();
    load_msgs();
    for (int i = 0; i < 2*N; i++) poke(8'(OB + i), 8'hA5);
    push_exp(7);
    @(negedge clk);
    init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
    repeat (29) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_wdata", 32'(mem_wdata), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    for (int i = 14; i < 2*N; i++) check("midrst_untouched", 32'(mem[OB + i]), 32'hA5);
    reset = 1'b1;
    push_exp(N);
    run(1'b0, "after_rst");

    // init chatter during a busy run
    randomize_msgs();
    load_msgs();
    push_exp(N);
    run(1'b1, "toggle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/secded_enc_engine.md
SECDED_ENC_ENGINE -- requirements
Module: secded_enc_engine

Interface
REQ-001 SHALL have parameter NUM_MSG, default 15: number of messages encoded per run.
REQ-002 SHALL have parameter IN_BASE, default 0: byte address of the first raw message.
REQ-003 SHALL have parameter OUT_BASE, default 30: byte address of the first encoded word.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port init, input, 1 bit: start request.
REQ-007 SHALL have port done, output, 1 bit: run-complete acknowledge.
REQ-008 SHALL have port mem_addr, output, 8 bits: data-memory byte address.
REQ-009 SHALL have port mem_rdata, input, 8 bits: data-memory read data, asynchronous (valid in the same cycle as mem_addr).
REQ-010 SHALL have port mem_wdata, output, 8 bits: data-memory write data.
REQ-011 SHALL have port mem_we, output, 1 bit: write enable; memory writes on the rising edge while this is high.

Function
REQ-012 SHALL store raw message i as follows: bits d[8:1] at byte IN_BASE+2i; d[11:9] in bits [2:0] of byte IN_BASE+2i+1; bits [7:3] of that byte ignored.
REQ-013 SHALL compute parity as: p8=^d[11:5]; p4=^d[11:8]^^d[4:2]; p2=d11^d10^d7^d6^d4^d3^d1; p1=d11^d9^d7^d5^d4^d2^d1; p0=^d[11:1]^p8^p4^p2^p1.
REQ-014 SHALL form the codeword c[15:0]={d[11:5],p8,d[4:2],p4,d1,p2,p1,p0}.
REQ-015 SHALL write c[7:0] to byte OUT_BASE+2i and c[15:8] to byte OUT_BASE+2i+1.
REQ-016 SHALL use FSM states IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE: moves to RD_LO when init=1, with msg counter=0.
- RD_LO: latches mem_rdata as the low byte; moves to RD_HI.
- RD_HI: latches mem_rdata[2:0]; moves to WR_LO.
- WR_LO: drives mem_we=1; moves to WR_HI.
- WR_HI: drives mem_we=1; moves to DONE if counter==NUM_MSG-1, otherwise increments the counter and moves to RD_LO.
- DONE: holds done=1; moves to RD_LO with counter=0 when init=1.
REQ-017 SHALL use a 4-cycle slot per message; done SHALL rise 4*NUM_MSG+1 rising edges after the edge that samples init in IDLE (61 for the default).
REQ-018 SHALL assert mem_we only in WR_LO and WR_HI.
REQ-019 SHALL hold mem_wdata=0 whenever mem_we=0.
REQ-020 SHALL ignore init while the FSM is in RD_LO, RD_HI, WR_LO or WR_HI; no restart and no corruption of the run in progress.
REQ-021 SHALL deassert done on the cycle after init restarts the engine from DONE.
REQ-022 SHALL make the address arithmetic 8 bits wide, with wrap-around beyond 255 permitted and not checked.
REQ-023 SHALL encode correctly when the input and output regions overlap in the same slot; each message's read precedes its own writes.

Reset
REQ-024 SHALL, on reset=0 and regardless of clk, force: state=IDLE, counter=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, data latches=0.
REQ-025 SHALL leave bytes already written untouched on a mid-run reset; no further writes occur until the next init.
REQ-026 SHALL treat reset deassertion as synchronous-release; the first state change is possible on the following rising edge.

Structure
REQ-027 SHALL place the following in shared package secded_pkg: the state enum type, DATA_W=11, CODE_W=16, ADDR_W=8, and the default NUM_MSG/IN_BASE/OUT_BASE constants.
REQ-028 SHALL implement the parity/codeword logic as combinational sub-module secded_enc (11-bit in, 16-bit out), reusable by the decoder team.
REQ-029 SHALL keep the FSM, counter and data latches in secded_enc_engine.

Verification
REQ-030 SHALL cover: all messages d=11'h000 -> every output word 16'h0000; done at edge 61.
REQ-031 SHALL cover: d=11'h7FF -> 16'hFFFF; d=11'h001 -> 16'h000F; d=11'h400 -> 16'h8117.
REQ-032 SHALL cover: high input byte 8'hF8 with low byte 8'h01 -> 16'h000F; bits [7:3] are ignored.
REQ-033 SHALL cover: 15 random messages checked against the REQ-013 model, plus a second init from DONE that re-encodes and makes done fall then rise again.
REQ-034 SHALL cover: reset pulsed low during message 7 -> outputs 0 immediately, slots 7-14 unwritten, a fresh init then completes all 15 correctly.
REQ-035 SHALL cover: init toggled during a busy run -> identical outputs and timing to an undisturbed run.
